// File: rtl/vending_machine_param.sv
// -----------------------------------------------------------------------------
// vending_machine_param
// Coin-operated vending controller with a parameterised product price.
// Accepts Re 1 / Rs 2 coins, delivers one product when the credit reaches
// PRICE, pays out change or a cancel refund one rupee per cycle, and bounces
// any coin that arrives while it is busy.
//
// Build option:
//   VEND_TIMEOUT_EN - when defined, credit left idle in COLLECT for
//                     TIMEOUT_CYCLES cycles is refunded automatically.
//                     When undefined, no counter exists and credit is held
//                     in COLLECT until a coin or cancel arrives.
// -----------------------------------------------------------------------------
module vending_machine_param #(
    parameter int PRICE          = 3,
    parameter int CREDIT_W       = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                prdt,
    output logic                ret,
    output logic                reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    // Elaboration-time parameter sanity: the price bound is what keeps
    // credit + 2 from wrapping in CREDIT_W bits.
    if ((PRICE < 1) || (PRICE > ((2 ** CREDIT_W) - 3))) begin : g_bad_price
        $error("vending_machine_param: PRICE out of range for CREDIT_W");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("vending_machine_param: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_VEND    = 3'd2,
        ST_CHANGE  = 3'd3,
        ST_REFUND  = 3'd4
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    // Face value of a coin given its denomination bit (0: Re 1, 1: Rs 2).
    function automatic logic [CREDIT_W-1:0] coin_value(input logic denom);
        logic [CREDIT_W-1:0] v;
        if (denom) begin
            v = CREDIT_W'(2);
        end else begin
            v = CREDIT_W'(1);
        end
        return v;
    endfunction

    state_t              state_r;
    state_t              state_s;
    state_t              accept_state_s;
    logic [CREDIT_W-1:0] credit_r;
    logic [CREDIT_W-1:0] credit_s;
    logic [CREDIT_W-1:0] sum_s;
    logic [CREDIT_W-1:0] accept_credit_s;
    logic                coin_valid_s;
    logic                reject_s;
    logic                prdt_r;
    logic                ret_r;
    logic                reject_r;
    logic                busy_r;

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_cnt_r;
    logic [TO_W-1:0] idle_cnt_s;
`endif

    // Decode the coin sensors and work out where an accepted coin would lead.
    always_comb begin
        coin_valid_s    = coin[1];
        sum_s           = credit_r + coin_value(coin[0]);
        accept_state_s  = ST_COLLECT;
        accept_credit_s = sum_s;
        if (sum_s >= PRICE_C) begin
            accept_state_s  = ST_VEND;
            accept_credit_s = sum_s - PRICE_C;
        end else begin
            accept_state_s  = ST_COLLECT;
            accept_credit_s = sum_s;
        end
    end

    // Next-state, next-credit and coin-bounce decision.
    always_comb begin
        state_s  = state_r;
        credit_s = credit_r;
        reject_s = 1'b0;
`ifdef VEND_TIMEOUT_EN
        idle_cnt_s = '0;
`endif
        case (state_r)
            ST_IDLE: begin
                // cancel is meaningless with no credit, so it is ignored here
                if (coin_valid_s) begin
                    state_s  = accept_state_s;
                    credit_s = accept_credit_s;
                end else begin
                    state_s  = ST_IDLE;
                    credit_s = '0;
                end
            end
            ST_COLLECT: begin
                if (cancel) begin
                    // cancel beats a simultaneous coin, which is bounced
                    state_s  = ST_REFUND;
                    reject_s = coin_valid_s;
                end else if (coin_valid_s) begin
                    state_s  = accept_state_s;
                    credit_s = accept_credit_s;
                end
`ifdef VEND_TIMEOUT_EN
                else if (idle_cnt_r >= TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_s = ST_REFUND;
                end else begin
                    state_s    = ST_COLLECT;
                    idle_cnt_s = idle_cnt_r + TO_W'(1);
                end
`else
                else begin
                    state_s = ST_COLLECT;
                end
`endif
            end
            ST_VEND: begin
                reject_s = coin_valid_s;
                if (credit_r != '0) begin
                    state_s = ST_CHANGE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHANGE, ST_REFUND: begin
                // credit here is the rupees still owed including the one
                // being returned this cycle
                reject_s = coin_valid_s;
                if (credit_r <= CREDIT_W'(1)) begin
                    state_s  = ST_IDLE;
                    credit_s = '0;
                end else begin
                    state_s  = state_r;
                    credit_s = credit_r - CREDIT_W'(1);
                end
            end
            default: begin
                state_s  = ST_IDLE;
                credit_s = '0;
            end
        endcase
    end

    // State, credit and registered output pulses, all decoded from next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            credit_r <= '0;
            prdt_r   <= 1'b0;
            ret_r    <= 1'b0;
            reject_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            credit_r <= credit_s;
            prdt_r   <= (state_s == ST_VEND);
            ret_r    <= (state_s == ST_CHANGE) || (state_s == ST_REFUND);
            reject_r <= reject_s;
            busy_r   <= (state_s == ST_VEND) || (state_s == ST_CHANGE) ||
                        (state_s == ST_REFUND);
        end
    end

`ifdef VEND_TIMEOUT_EN
    // Idle-cycle counter for the automatic refund of abandoned credit.
    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt_r <= '0;
        end else begin
            idle_cnt_r <= idle_cnt_s;
        end
    end
`endif

    assign prdt   = prdt_r;
    assign ret    = ret_r;
    assign reject = reject_r;
    assign busy   = busy_r;
    assign credit = credit_r;

endmodule

// File: tb/tb_vending_machine_param.sv
// -----------------------------------------------------------------------------
// tb_vending_machine_param
// Drives two machines (PRICE=3 and PRICE=5) with the same coin/cancel/reset
// stream and compares every output each cycle against a reference model that
// treats a vend or refund as a schedule of output cycles held in a queue.
// -----------------------------------------------------------------------------
module tb_vending_machine_param;

    typedef struct packed {
        logic       prdt;
        logic       ret;
        logic       busy;
        logic [3:0] credit;
    } out_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] coin;
    logic       cancel;

    logic       prdt3, ret3, reject3, busy3;
    logic [3:0] credit3;
    logic       prdt5, ret5, reject5, busy5;
    logic [3:0] credit5;

    int n_vec = 0;
    int n_err = 0;

    // reference model state, index 0: PRICE=3, index 1: PRICE=5
    int   price   [2] = '{3, 5};
    out_t cur     [2];
    out_t sched   [2][$];
    int   mcredit [2];
    logic rej     [2];
`ifdef VEND_TIMEOUT_EN
    int   idle_cnt[2];
`endif

    vending_machine_param #(.PRICE(3), .CREDIT_W(4), .TIMEOUT_CYCLES(8)) dut3 (
        .clock(clock), .reset(reset), .coin(coin), .cancel(cancel),
        .prdt(prdt3), .ret(ret3), .reject(reject3), .busy(busy3), .credit(credit3)
    );

    vending_machine_param #(.PRICE(5), .CREDIT_W(4), .TIMEOUT_CYCLES(8)) dut5 (
        .clock(clock), .reset(reset), .coin(coin), .cancel(cancel),
        .prdt(prdt5), .ret(ret5), .reject(reject5), .busy(busy5), .credit(credit5)
    );

    always #5 clock = ~clock;

    // queue one ret cycle per rupee owed, largest remaining amount first
    task automatic model_refund(input int i);
        for (int k = mcredit[i]; k >= 1; k--) begin
            sched[i].push_back(out_t'{1'b0, 1'b1, 1'b1, 4'(k)});
        end
        mcredit[i] = 0;
`ifdef VEND_TIMEOUT_EN
        idle_cnt[i] = 0;
`endif
    endtask

    // advance machine i by one clock edge with the given sampled inputs
    task automatic model_edge(input int i, input logic [1:0] c, input logic cn, input logic r);
        bit have_coin;
        int val;
        int sum;
        have_coin = (c[1] == 1'b1);
        val       = (c[0] == 1'b1) ? 2 : 1;
        rej[i]    = 1'b0;
        if (r) begin
            sched[i].delete();
            cur[i]     = out_t'{1'b0, 1'b0, 1'b0, 4'd0};
            mcredit[i] = 0;
`ifdef VEND_TIMEOUT_EN
            idle_cnt[i] = 0;
`endif
            return;
        end
        if (cur[i].busy) begin
            if (have_coin) rej[i] = 1'b1;
        end else if (cn && (mcredit[i] > 0)) begin
            if (have_coin) rej[i] = 1'b1;
            model_refund(i);
        end else if (have_coin) begin
`ifdef VEND_TIMEOUT_EN
            idle_cnt[i] = 0;
`endif
            sum = mcredit[i] + val;
            if (sum >= price[i]) begin
                mcredit[i] = sum - price[i];
                sched[i].push_back(out_t'{1'b1, 1'b0, 1'b1, 4'(mcredit[i])});
                model_refund(i);
            end else begin
                mcredit[i] = sum;
            end
        end else if (mcredit[i] > 0) begin
`ifdef VEND_TIMEOUT_EN
            idle_cnt[i]++;
            if (idle_cnt[i] >= 8) model_refund(i);
`endif
        end
        if (sched[i].size() > 0) begin
            cur[i] = sched[i].pop_front();
        end else begin
            cur[i] = out_t'{1'b0, 1'b0, 1'b0, 4'(mcredit[i])};
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    // apply one cycle of inputs, step the model, then compare after the edge
    task automatic step(input logic [1:0] c, input logic cn, input logic r);
        coin   = c;
        cancel = cn;
        reset  = r;
        @(posedge clock);
        model_edge(0, c, cn, r);
        model_edge(1, c, cn, r);
        #1;
        chk("p3.prdt",   {3'd0, prdt3},   {3'd0, cur[0].prdt});
        chk("p3.ret",    {3'd0, ret3},    {3'd0, cur[0].ret});
        chk("p3.reject", {3'd0, reject3}, {3'd0, rej[0]});
        chk("p3.busy",   {3'd0, busy3},   {3'd0, cur[0].busy});
        chk("p3.credit", credit3,         cur[0].credit);
        chk("p5.prdt",   {3'd0, prdt5},   {3'd0, cur[1].prdt});
        chk("p5.ret",    {3'd0, ret5},    {3'd0, cur[1].ret});
        chk("p5.reject", {3'd0, reject5}, {3'd0, rej[1]});
        chk("p5.busy",   {3'd0, busy5},   {3'd0, cur[1].busy});
        chk("p5.credit", credit5,         cur[1].credit);
    endtask

    initial begin
        int sel;
        logic [1:0] rc;
        coin   = 2'b00;
        cancel = 1'b0;
        reset  = 1'b1;

        // reset state
        step(2'b00, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b1);

        // Re 1 then Rs 2: exact price, no change
        step(2'b10, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        repeat (4) step(2'b00, 1'b0, 1'b0);

        // Rs 2 twice: one rupee change
        step(2'b11, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        repeat (4) step(2'b00, 1'b0, 1'b0);

        // two Re 1 then cancel: two-rupee refund; cancel in IDLE ignored
        step(2'b00, 1'b1, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b0);
        repeat (6) step(2'b00, 1'b0, 1'b0);

        // coin during CHANGE bounced; then cancel plus coin in COLLECT
        step(2'b11, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        repeat (6) step(2'b00, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        step(2'b11, 1'b1, 1'b0);
        repeat (6) step(2'b00, 1'b0, 1'b0);

        // three Rs 2 coins (PRICE=5 vends with one rupee change)
        step(2'b00, 1'b0, 1'b1);
        step(2'b11, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        repeat (6) step(2'b00, 1'b0, 1'b0);

        // abandoned credit: refunded after 8 idle cycles only with the timeout
        step(2'b00, 1'b0, 1'b1);
        step(2'b11, 1'b0, 1'b0);
        repeat (14) step(2'b00, 1'b0, 1'b0);

        // reset in the middle of a refund drops the rest of it
        step(2'b00, 1'b0, 1'b1);
        step(2'b11, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b1);
        repeat (4) step(2'b00, 1'b0, 1'b0);

        // reset during VEND drops the owed change
        step(2'b11, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b1);
        repeat (3) step(2'b00, 1'b0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 3));
            rc  = 2'(sel);
            step(rc, ($urandom_range(0, 7) == 0), ($urandom_range(0, 249) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
